// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants and FSM state encoding for the I2C byte receiver
package i2c_pkg;

  localparam int BYTE_BITS  = 8;
  localparam int SYNC_DEPTH = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_RX_BITS    = 3'd1;
  localparam state_t ST_ACK_DRIVE  = 3'd2;
  localparam state_t ST_ACK_HOLD   = 3'd3;
  localparam state_t ST_ADDR_CHECK = 3'd4;

endpackage

// File: rtl/i2c_byte_rx_if.sv
// rtl/i2c_byte_rx_if.sv - bundle of the receiver's bus-side and consumer-side signals
interface i2c_byte_rx_if;
  import i2c_pkg::*;

  logic                 sda_in;
  logic                 rising_edge_found;
  logic                 falling_edge_found;
  logic                 rx_read;
  logic                 ack_enable;
  logic [BYTE_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_full;
  logic                 rx_overrun;
  logic                 start_found;
  logic                 stop_found;
  logic                 sda_drive_low;
  logic                 busy;

  modport master (
    output sda_in, rising_edge_found, falling_edge_found, rx_read, ack_enable,
    input  rx_data, rx_valid, rx_full, rx_overrun, start_found, stop_found,
           sda_drive_low, busy
  );

  modport slave (
    input  sda_in, rising_edge_found, falling_edge_found, rx_read, ack_enable,
    output rx_data, rx_valid, rx_full, rx_overrun, start_found, stop_found,
           sda_drive_low, busy
  );

endinterface

// File: rtl/sda_sync.sv
// rtl/sda_sync.sv - flop-chain synchronizer for the asynchronous SDA line, resets to the idle-high level
module sda_sync #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/i2c_byte_rx.sv
// rtl/i2c_byte_rx.sv - I2C slave byte receiver with ACK/NACK generation
// Optional address filtering of the first byte after START: I2C_RX_ADDR_FILTER_EN
module i2c_byte_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sda_in,
  input  logic                 rising_edge_found,
  input  logic                 falling_edge_found,
  input  logic                 rx_read,
  input  logic                 ack_enable,
  output logic [BYTE_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_full,
  output logic                 rx_overrun,
  output logic                 start_found,
  output logic                 stop_found,
  output logic                 sda_drive_low,
  output logic                 busy
);

  logic                 sda_s;
  logic                 sda_prev_q, sda_prev_d;
  logic                 scl_q, scl_d;
  state_t               state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [BYTE_BITS-1:0] shift_q, shift_d;
  logic [BYTE_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_full_q, rx_full_d;
  logic                 rx_overrun_q, rx_overrun_d;
  logic                 start_found_q, start_found_d;
  logic                 stop_found_q, stop_found_d;
  logic                 drive_q, drive_d;
  logic                 start_det, stop_det;

  sda_sync #(.DEPTH(SYNC_DEPTH)) u_sda_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (sda_in),
    .q     (sda_s)
  );

  // SDA transitions while SCL is high are bus conditions, never data.
  assign start_det = scl_q &  sda_prev_q & ~sda_s;
  assign stop_det  = scl_q & ~sda_prev_q &  sda_s;

`ifdef I2C_RX_ADDR_FILTER_EN
  logic first_q, first_d;
`else
  logic unused_slave_addr;
  assign unused_slave_addr = ^SLAVE_ADDR;
`endif

  always_comb begin
    sda_prev_d    = sda_s;
    scl_d         = scl_q;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_full_d     = rx_full_q;
    rx_overrun_d  = rx_overrun_q;
    start_found_d = start_det;
    stop_found_d  = stop_det;
    drive_d       = drive_q;
`ifdef I2C_RX_ADDR_FILTER_EN
    first_d       = first_q;
`endif

    if (rising_edge_found) begin
      scl_d = 1'b1;
    end else if (falling_edge_found) begin
      scl_d = 1'b0;
    end

    if (rx_read) begin
      rx_full_d = 1'b0;
    end

    if (start_det) begin
      state_d      = ST_RX_BITS;
      bit_cnt_d    = '0;
      shift_d      = '0;
      rx_overrun_d = 1'b0;
      drive_d      = 1'b0;
`ifdef I2C_RX_ADDR_FILTER_EN
      first_d      = 1'b1;
`endif
    end else if (stop_det) begin
      state_d = ST_IDLE;
      drive_d = 1'b0;
    end else begin
      case (state_q)
        ST_RX_BITS: begin
          if (rising_edge_found) begin
            shift_d   = {shift_q[BYTE_BITS-2:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(BYTE_BITS - 1)) begin
`ifdef I2C_RX_ADDR_FILTER_EN
              if (first_q) begin
                state_d = ST_ADDR_CHECK;
              end else
`endif
              begin
                // A load always wins over a same-cycle rx_read.
                rx_data_d  = shift_d;
                rx_valid_d = 1'b1;
                rx_full_d  = 1'b1;
                if (rx_full_q) begin
                  rx_overrun_d = 1'b1;
                end
                state_d = ST_ACK_DRIVE;
              end
            end
          end
        end
`ifdef I2C_RX_ADDR_FILTER_EN
        ST_ADDR_CHECK: begin
          first_d = 1'b0;
          state_d = (shift_q[7:1] == SLAVE_ADDR) ? ST_ACK_DRIVE : ST_IDLE;
        end
`endif
        ST_ACK_DRIVE: begin
          if (falling_edge_found) begin
            drive_d = ack_enable & ~rx_overrun_q;
            state_d = ST_ACK_HOLD;
          end
        end
        ST_ACK_HOLD: begin
          if (falling_edge_found) begin
            drive_d   = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_RX_BITS;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sda_prev_q    <= 1'b1;
      scl_q         <= 1'b1;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_full_q     <= 1'b0;
      rx_overrun_q  <= 1'b0;
      start_found_q <= 1'b0;
      stop_found_q  <= 1'b0;
      drive_q       <= 1'b0;
`ifdef I2C_RX_ADDR_FILTER_EN
      first_q       <= 1'b0;
`endif
    end else begin
      sda_prev_q    <= sda_prev_d;
      scl_q         <= scl_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_full_q     <= rx_full_d;
      rx_overrun_q  <= rx_overrun_d;
      start_found_q <= start_found_d;
      stop_found_q  <= stop_found_d;
      drive_q       <= drive_d;
`ifdef I2C_RX_ADDR_FILTER_EN
      first_q       <= first_d;
`endif
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_full       = rx_full_q;
  assign rx_overrun    = rx_overrun_q;
  assign start_found   = start_found_q;
  assign stop_found    = stop_found_q;
  assign sda_drive_low = drive_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_byte_rx.sv
// tb/tb_i2c_byte_rx.sv - directed scoreboard bench for i2c_byte_rx
module tb_i2c_byte_rx;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  i2c_byte_rx_if bus ();

  i2c_byte_rx #(.SLAVE_ADDR(7'h3C)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .sda_in             (bus.sda_in),
    .rising_edge_found  (bus.rising_edge_found),
    .falling_edge_found (bus.falling_edge_found),
    .rx_read            (bus.rx_read),
    .ack_enable         (bus.ack_enable),
    .rx_data            (bus.rx_data),
    .rx_valid           (bus.rx_valid),
    .rx_full            (bus.rx_full),
    .rx_overrun         (bus.rx_overrun),
    .start_found        (bus.start_found),
    .stop_found         (bus.stop_found),
    .sda_drive_low      (bus.sda_drive_low),
    .busy               (bus.busy)
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_fail    = 0;
  logic [7:0] exp_q[$];
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  int         exp_start = 0;
  int         exp_stop  = 0;
  logic       valid_prev = 1'b0;
  logic       start_prev = 1'b0;
  logic       stop_prev  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every rx_valid and counts bus-condition pulses.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      chk("rx_valid_width", valid_prev, 1'b0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got byte %0h expected no rx_valid", bus.rx_data);
      end else begin
        chk("rx_data", bus.rx_data, exp_q.pop_front());
      end
    end
    if (bus.start_found) begin
      chk("start_width", start_prev, 1'b0);
      start_cnt <= start_cnt + 1;
    end
    if (bus.stop_found) begin
      chk("stop_width", stop_prev, 1'b0);
      stop_cnt <= stop_cnt + 1;
    end
    valid_prev <= bus.rx_valid;
    start_prev <= bus.start_found;
    stop_prev  <= bus.stop_found;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sda(input logic v);
    bus.sda_in = v;
    repeat (5) tick();
  endtask

  task automatic pulse_rise();
    bus.rising_edge_found = 1'b1;
    tick();
    bus.rising_edge_found = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_fall();
    bus.falling_edge_found = 1'b1;
    tick();
    bus.falling_edge_found = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      set_sda(b[i]);
      pulse_rise();
      pulse_fall();
    end
  endtask

  // Ninth clock: sda_drive_low must hold its value across one low and one high phase only.
  task automatic ack_cycle(input logic exp_ack);
    chk("ack_low_phase", bus.sda_drive_low, exp_ack);
    pulse_rise();
    chk("ack_high_phase", bus.sda_drive_low, exp_ack);
    pulse_fall();
    chk("ack_released", bus.sda_drive_low, 1'b0);
  endtask

  task automatic send_data(input logic [7:0] b, input logic exp_ack);
    exp_q.push_back(b);
    send_bits(b, 8);
    ack_cycle(exp_ack);
  endtask

  // Expects SCL high and SDA high on entry.
  task automatic do_start();
    set_sda(1'b0);
    exp_start++;
    chk("start_cnt", start_cnt, exp_start);
    chk("busy_after_start", bus.busy, 1'b1);
    chk("overrun_cleared", bus.rx_overrun, 1'b0);
    pulse_fall();
`ifdef I2C_RX_ADDR_FILTER_EN
    send_bits({7'h3C, 1'b0}, 8);
    ack_cycle(1'b1);
`endif
  endtask

  // Expects SCL low on entry.
  task automatic do_stop();
    set_sda(1'b0);
    pulse_rise();
    set_sda(1'b1);
    exp_stop++;
    chk("stop_cnt", stop_cnt, exp_stop);
    chk("busy_after_stop", bus.busy, 1'b0);
    chk("drive_after_stop", bus.sda_drive_low, 1'b0);
  endtask

  task automatic read_byte();
    bus.rx_read = 1'b1;
    tick();
    bus.rx_read = 1'b0;
    chk("rx_full_after_read", bus.rx_full, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_data"}, bus.rx_data, 8'h00);
    chk({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
    chk({tag, "_rx_full"}, bus.rx_full, 1'b0);
    chk({tag, "_rx_overrun"}, bus.rx_overrun, 1'b0);
    chk({tag, "_start_found"}, bus.start_found, 1'b0);
    chk({tag, "_stop_found"}, bus.stop_found, 1'b0);
    chk({tag, "_drive"}, bus.sda_drive_low, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    bus.sda_in             = 1'b1;
    bus.rising_edge_found  = 1'b0;
    bus.falling_edge_found = 1'b0;
    bus.rx_read            = 1'b0;
    bus.ack_enable         = 1'b1;
    n_rst                  = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    n_rst = 1'b1;
    repeat (4) tick();

    // Single byte with ACK.
    do_start();
    send_data(8'hA5, 1'b1);
    chk("rx_full_a5", bus.rx_full, 1'b1);
    read_byte();
    do_stop();

    // Two unread bytes: second overruns and is NACKed.
    do_start();
    send_data(8'h12, 1'b1);
    send_data(8'h34, 1'b0);
    chk("rx_overrun_set", bus.rx_overrun, 1'b1);
    chk("rx_full_overrun", bus.rx_full, 1'b1);
    do_stop();
    chk("rx_overrun_sticky", bus.rx_overrun, 1'b1);
    read_byte();

    // Repeated START after four bits discards the partial byte.
    do_start();
    send_bits(8'hA0, 4);
    set_sda(1'b1);
    pulse_rise();
    do_start();
    send_data(8'h0F, 1'b1);
    read_byte();
    do_stop();

    // ack_enable low gives NACK on a clean byte.
    do_start();
    bus.ack_enable = 1'b0;
    send_data(8'h5A, 1'b0);
    bus.ack_enable = 1'b1;
    read_byte();
    do_stop();

    // STOP while the ACK is being held.
    do_start();
    exp_q.push_back(8'hC3);
    send_bits(8'hC3, 8);
    chk("drive_before_stop", bus.sda_drive_low, 1'b1);
    set_sda(1'b0);
    pulse_rise();
    chk("drive_in_ack_hold", bus.sda_drive_low, 1'b1);
    set_sda(1'b1);
    exp_stop++;
    chk("stop_cnt_ack_hold", stop_cnt, exp_stop);
    chk("drive_stop_ack_hold", bus.sda_drive_low, 1'b0);
    chk("busy_stop_ack_hold", bus.busy, 1'b0);
    read_byte();

    // One-cycle reset in the middle of a byte.
    do_start();
    send_bits(8'hE0, 3);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk_reset_outputs("midreset");
    repeat (4) tick();
    do_start();
    send_data(8'hFF, 1'b1);
    read_byte();
    do_stop();

`ifdef I2C_RX_ADDR_FILTER_EN
    // Foreign address: no ACK, nothing delivered until the next START.
    set_sda(1'b0);
    exp_start++;
    chk("start_cnt_foreign", start_cnt, exp_start);
    pulse_fall();
    send_bits({7'h11, 1'b0}, 8);
    ack_cycle(1'b0);
    chk("busy_foreign", bus.busy, 1'b0);
    send_bits(8'h55, 8);
    ack_cycle(1'b0);
    chk("rx_full_foreign", bus.rx_full, 1'b0);
    do_stop();
    do_start();
    send_data(8'h66, 1'b1);
    read_byte();
    do_stop();
`endif

    repeat (10) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_byte_rx.md
I2C_BYTE_RX -- requirements
Module: i2c_byte_rx

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h3C, the 7-bit address used only when I2C_RX_ADDR_FILTER_EN is defined.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: reset; synchronous, active-low.
REQ-004 SHALL have port sda_in, input, 1 bit: raw, asynchronous I2C SDA line.
REQ-005 SHALL have port rising_edge_found, input, 1 bit: one-cycle pulse from the upstream SCL edge detector.
REQ-006 SHALL have port falling_edge_found, input, 1 bit: one-cycle pulse from the upstream SCL edge detector.
REQ-007 SHALL have port rx_read, input, 1 bit: consumer pulse that empties the holding register.
REQ-008 SHALL have port ack_enable, input, 1 bit: when 1, received bytes are ACKed; when 0, they are NACKed.
REQ-009 SHALL have port rx_data, output, 8 bits: last received byte.
REQ-010 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-011 SHALL have port rx_full, output, 1 bit: the holding register contains an unread byte.
REQ-012 SHALL have port rx_overrun, output, 1 bit: sticky flag; a byte arrived while rx_full was 1.
REQ-013 SHALL have port start_found, output, 1 bit: one-cycle pulse on a START or repeated START.
REQ-014 SHALL have port stop_found, output, 1 bit: one-cycle pulse on a STOP.
REQ-015 SHALL have port sda_drive_low, output, 1 bit: pulls SDA low for the ACK bit.
REQ-016 SHALL have port busy, output, 1 bit: asserted when the state is not IDLE.

Function
REQ-017 SHALL pass sda_in through a 3-flop synchronizer (reset value 1), so that SDA aligns with the edge pulses, which arrive 3 cycles after SCL changes.
REQ-018 SHALL track the SCL level internally: set to 1 on rising_edge_found, cleared to 0 on falling_edge_found; reset value 1.
REQ-019 SHALL detect START when synchronized SDA goes 1->0 while SCL level is 1; start_found pulses the next cycle.
REQ-020 SHALL detect STOP when synchronized SDA goes 0->1 while SCL level is 1; stop_found pulses the next cycle.
REQ-021 SHALL implement FSM states IDLE, RX_BITS, ACK_DRIVE, ACK_HOLD, plus ADDR_CHECK when filtering is compiled in.
REQ-022 SHALL, in any state, on START clear bit_cnt and the shift register and enter RX_BITS; START and STOP take priority over same-cycle edge pulses.
REQ-023 SHALL, in any state, on STOP enter IDLE and deassert sda_drive_low in the same cycle.
REQ-024 SHALL, in RX_BITS on each rising_edge_found, shift synchronized SDA MSB-first into an 8-bit register and increment a 3-bit bit_cnt, which wraps from 7 to 0.
REQ-025 SHALL, on the 8th rising edge (bit_cnt==7), load rx_data, pulse rx_valid the next cycle, set rx_full, and enter ACK_DRIVE.
REQ-026 SHALL set rx_overrun and overwrite rx_data if rx_full is already 1 at the load cycle; rx_overrun clears only on reset or START.
REQ-027 SHALL, in ACK_DRIVE on falling_edge_found, assert sda_drive_low = ack_enable & ~rx_overrun and enter ACK_HOLD.
REQ-028 SHALL, in ACK_HOLD on the next falling_edge_found, deassert sda_drive_low and return to RX_BITS with bit_cnt=0.
REQ-029 SHALL clear rx_full on rx_read; if rx_read and a load occur in the same cycle, the load wins and rx_full stays 1.
REQ-030 SHALL ignore edge pulses while in IDLE.

Reset
REQ-031 SHALL, on n_rst==0 at a clk rising edge, set state=IDLE, bit_cnt=0, shift register=0, rx_data=8'h00, SCL level=1, and all synchronizer flops=1.
REQ-032 SHALL drive rx_valid, rx_full, rx_overrun, start_found, stop_found, sda_drive_low and busy to 0 during and after reset; a reset mid-byte discards partial data.

Configuration
REQ-033 SHALL, with I2C_RX_ADDR_FILTER_EN defined, treat the first byte after START as an address: compare bits [7:1] against SLAVE_ADDR in ADDR_CHECK; on a match, ACK, skip rx_valid/rx_full, and continue; on a mismatch, enter IDLE with no ACK until the next START.
REQ-034 SHALL, without I2C_RX_ADDR_FILTER_EN, omit ADDR_CHECK and deliver every byte, including the first, through rx_data.

Structure
REQ-035 SHALL take the FSM state enum and constants BYTE_BITS=8 and SYNC_DEPTH=3 from the shared package i2c_pkg.
REQ-036 SHALL instantiate one sub-module, sda_sync (parameterizable-depth flop synchronizer); all other logic stays in i2c_byte_rx.

Verification
REQ-037 SHALL cover: START, byte 8'hA5, ack_enable=1 -> start_found pulse; rx_data=8'hA5; rx_valid 1 cycle; sda_drive_low high for exactly one SCL low/high ACK period.
REQ-038 SHALL cover: two bytes 8'h12 then 8'h34 with no rx_read -> rx_data=8'h34, rx_overrun=1, second ACK replaced by NACK (sda_drive_low stays 0).
REQ-039 SHALL cover: repeated START after 4 bits -> partial bits discarded; the next full byte 8'h0F is received correctly.
REQ-040 SHALL cover: STOP during ACK_HOLD -> sda_drive_low=0 the same cycle, stop_found pulse, busy=0.
REQ-041 SHALL cover: n_rst low for 1 cycle mid-byte -> all outputs 0, rx_data=8'h00; the next START and byte 8'hFF are received cleanly.
REQ-042 SHALL cover, with I2C_RX_ADDR_FILTER_EN defined: address byte {7'h3C,1'b0} -> ACK and no rx_valid; address {7'h11,1'b0} -> no ACK and no rx_valid until the next START.
